// File: rtl/envelope_pkg.sv
// envelope_pkg: shared state encoding, register map and STATUS layout for the ADSR envelope
package envelope_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_RATES   = 2'd1;
  localparam logic [1:0] REG_SUSTAIN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_STATE_LSB = 8;
endpackage

// File: rtl/envelope_adsr_if.sv
// envelope_adsr_if: valid/ready peripheral bus between the CPU decode and the envelope block
interface envelope_adsr_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/env_vca.sv
// env_vca: registered sample x level multiply keeping the top DATA_W bits
module env_vca #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] sample,
  input  logic [7:0]        level,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W+7:0] prod;
  logic              unused_lsb;
  assign prod = {8'd0, sample} * {{DATA_W{1'b0}}, level};
  assign unused_lsb = ^prod[7:0];
  always_ff @(posedge clk)
    out <= !resetn ? '0 : prod[DATA_W+7:8];
endmodule

// File: rtl/envelope_adsr.sv
// envelope_adsr: memory-mapped ADSR envelope generator driving a VCA on one oscillator channel
module envelope_adsr
  import envelope_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  envelope_adsr_if.slave    bus,
  input  logic [DATA_W-1:0] in,
  input  logic              tick,
  output logic [DATA_W-1:0] out,
  output logic              active
);
  env_state_t       state;
  logic [ACC_W-1:0] acc, target, att_sat;
  logic [ACC_W:0]   att_sum, dec_diff, rel_diff;
  logic [7:0]       a_rate, d_rate, r_rate, sus, level;
  logic [31:0]      status, rd_val;
  logic [1:0]       sel;
  logic             gate, gate_q, access, dec_done, rel_done, unused;
  assign sel    = bus.addr[3:2];
  assign access = bus.valid && !bus.ready;
  assign level  = acc[ACC_W-1 -: 8];
  assign target = {sus, {(ACC_W-8){1'b0}}};
  assign active = state != IDLE;
  assign unused = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:24], bus.wstrb[3]};
  // One extra bit on each step exposes overflow/underflow of the accumulator
  always_comb begin
    att_sum  = {1'b0, acc} + {{(ACC_W-7){1'b0}}, a_rate};
    dec_diff = {1'b0, acc} - {{(ACC_W-7){1'b0}}, d_rate};
    rel_diff = {1'b0, acc} - {{(ACC_W-7){1'b0}}, r_rate};
    att_sat  = att_sum[ACC_W] ? '1 : att_sum[ACC_W-1:0];
    dec_done = dec_diff[ACC_W] || dec_diff[ACC_W-1:0] <= target;
    rel_done = rel_diff[ACC_W] || ~|rel_diff[ACC_W-1:0];
    status   = '0;
    status[STAT_LEVEL_LSB +: 8] = level;
    status[STAT_STATE_LSB +: 3] = state;
    rd_val = sel == REG_CTRL    ? {31'd0, gate} :
             sel == REG_RATES   ? {8'd0, r_rate, d_rate, a_rate} :
             sel == REG_SUSTAIN ? {24'd0, sus} : status;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      gate      <= 1'b0;
      a_rate    <= '0;
      d_rate    <= '0;
      r_rate    <= '0;
      sus       <= '0;
    end else begin
      bus.ready <= access;
      bus.rdata <= access ? rd_val : '0;
      if (access && sel == REG_CTRL && bus.wstrb[0]) gate <= bus.wdata[0];
      if (access && sel == REG_RATES) begin
        if (bus.wstrb[0]) a_rate <= bus.wdata[7:0];
        if (bus.wstrb[1]) d_rate <= bus.wdata[15:8];
        if (bus.wstrb[2]) r_rate <= bus.wdata[23:16];
      end
      if (access && sel == REG_SUSTAIN && bus.wstrb[0]) sus <= bus.wdata[7:0];
    end
  end
  // Gate edges take priority over the sample tick; a tick coinciding with one is dropped
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      acc    <= '0;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (gate && !gate_q) state <= ATTACK;
      else if (!gate && gate_q) state <= active ? RELEASE : IDLE;
      else begin
        case (state)
          ATTACK: if (tick && |a_rate) begin
            acc   <= att_sat;
            state <= &att_sat ? DECAY : ATTACK;
          end
          DECAY: if (tick && |d_rate) begin
            acc   <= dec_done ? target : dec_diff[ACC_W-1:0];
            state <= dec_done ? SUSTAIN : DECAY;
          end
          SUSTAIN: acc <= target;
          RELEASE: if (tick && |r_rate) begin
            acc   <= rel_done ? '0 : rel_diff[ACC_W-1:0];
            state <= rel_done ? IDLE : RELEASE;
          end
          default: acc <= '0;
        endcase
      end
    end
  end
  env_vca #(.DATA_W(DATA_W)) u_vca (
    .clk    (clk),
    .resetn (resetn),
    .sample (in),
    .level  (level),
    .out    (out)
  );
endmodule

// File: tb/tb_envelope_adsr.sv
// tb_envelope_adsr: directed and random checks of envelope_adsr against an integer ADSR model
module tb_envelope_adsr;
  logic       clk = 1'b0, resetn = 1'b0, tick = 1'b0, active;
  logic [7:0] in_s = 8'd0, out;
  envelope_adsr_if bus();
  envelope_adsr #(.DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .in(in_s), .tick(tick), .out(out), .active(active)
  );
  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int m_acc, m_st, m_out, m_a, m_d, m_r, m_s;
  bit m_gate, m_gate_q, pw_en;
  logic [1:0]  pw_sel;
  logic [31:0] pw_data;
  logic [3:0]  pw_strb;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [1:0] s);
    case (s)
      2'd0:    return {31'd0, m_gate};
      2'd1:    return 32'(m_r * 65536 + m_d * 256 + m_a);
      2'd2:    return 32'(m_s);
      default: return 32'(m_st * 256 + m_acc / 256);
    endcase
  endfunction

  // Envelope rules in integer arithmetic; states: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  task automatic model_edge();
    int t;
    if (!resetn) begin
      m_acc = 0; m_st = 0; m_out = 0; m_a = 0; m_d = 0; m_r = 0; m_s = 0;
      m_gate = 0; m_gate_q = 0; pw_en = 0;
      return;
    end
    t = m_s * 256;
    m_out = int'(in_s) * (m_acc / 256) / 256;
    if (m_gate && !m_gate_q) m_st = 1;
    else if (!m_gate && m_gate_q) begin
      if (m_st != 0) m_st = 4;
    end else if (m_st == 3) m_acc = t;
    else if (tick) begin
      if (m_st == 1 && m_a > 0) begin
        m_acc = (m_acc + m_a >= 65535) ? 65535 : m_acc + m_a;
        if (m_acc == 65535) m_st = 2;
      end else if (m_st == 2 && m_d > 0) begin
        if (m_acc - m_d <= t) begin m_acc = t; m_st = 3; end
        else m_acc -= m_d;
      end else if (m_st == 4 && m_r > 0) begin
        if (m_acc - m_r <= 0) begin m_acc = 0; m_st = 0; end
        else m_acc -= m_r;
      end
    end
    m_gate_q = m_gate;
    if (pw_en) begin
      if (pw_sel == 2'd0 && pw_strb[0]) m_gate = pw_data[0];
      if (pw_sel == 2'd1 && pw_strb[0]) m_a = int'(pw_data[7:0]);
      if (pw_sel == 2'd1 && pw_strb[1]) m_d = int'(pw_data[15:8]);
      if (pw_sel == 2'd1 && pw_strb[2]) m_r = int'(pw_data[23:16]);
      if (pw_sel == 2'd2 && pw_strb[0]) m_s = int'(pw_data[7:0]);
      pw_en = 0;
    end
  endtask

  task automatic step(bit t);
    tick = t;
    @(posedge clk);
    model_edge();
    #1;
    tick = 1'b0;
    chk("out", {24'd0, out}, 32'(m_out));
    chk("active", {31'd0, active}, {31'd0, m_st != 0});
  endtask

  task automatic ticks(int n, int gap);
    repeat (n) begin
      step(1'b1);
      repeat (gap) step(1'b0);
    end
  endtask

  task automatic bus_op(logic [1:0] s, logic [31:0] d, logic [3:0] b, bit t2, output logic [31:0] rd);
    logic [31:0] exp_rd;
    exp_rd    = m_read(s);
    bus.valid = 1'b1;
    bus.addr  = 32'h0D000000 | {28'd0, s, 2'b00};
    bus.wdata = d;
    bus.wstrb = b;
    chk("ready_pre", {31'd0, bus.ready}, 32'd0);
    pw_en = b != 4'd0; pw_sel = s; pw_data = d; pw_strb = b;
    step(1'b0);
    chk("ready_ack", {31'd0, bus.ready}, 32'd1);
    rd = bus.rdata;
    if (b == 4'd0) chk("rdata", bus.rdata, exp_rd);
    step(t2);
    chk("ready_drop", {31'd0, bus.ready}, 32'd0);
    bus.valid = 1'b0;
    bus.wstrb = 4'd0;
  endtask

  task automatic wr(logic [1:0] s, logic [31:0] d, logic [3:0] b);
    logic [31:0] v;
    bus_op(s, d, b, 1'b0, v);
  endtask

  task automatic rd(logic [1:0] s, logic [31:0] exp, string tag);
    logic [31:0] v;
    bus_op(s, 32'd0, 4'd0, 1'b0, v);
    chk(tag, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    bus.valid = 1'b0; bus.wstrb = 4'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    repeat (3) step(1'b0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    resetn = 1'b1;
    rd(2'd3, 32'd0, "status_after_reset");
    in_s = 8'hC8;
    wr(2'd1, 32'h00801040, 4'b0111);
    wr(2'd2, 32'h00000080, 4'b0001);
    wr(2'd0, 32'd1, 4'b0001);
    ticks(1023, 3);
    rd(2'd3, 32'h1FF, "attack_1023");
    ticks(1, 3);
    rd(2'd3, 32'h2FF, "decay_entry");
    ticks(2047, 3);
    rd(2'd3, 32'h280, "decay_2047");
    ticks(1, 3);
    rd(2'd3, 32'h380, "sustain_entry");
    step(1'b0);
    chk("out_sustain", {24'd0, out}, 32'h64);
    wr(2'd0, 32'd0, 4'b0001);
    ticks(255, 3);
    rd(2'd3, 32'h400, "release_255");
    ticks(1, 3);
    rd(2'd3, 32'h000, "release_idle");
    chk("active_idle", {31'd0, active}, 32'd0);
    chk("out_idle", {24'd0, out}, 32'd0);
    wr(2'd0, 32'd1, 4'b0001);
    ticks(192, 1);
    rd(2'd3, 32'h130, "attack_0x30");
    wr(2'd0, 32'd0, 4'b0001);
    wr(2'd0, 32'd1, 4'b0001);
    rd(2'd3, 32'h130, "retrigger_keeps_level");
    bus_op(2'd0, 32'd0, 4'b0001, 1'b1, v);
    rd(2'd3, 32'h430, "tick_dropped_on_gate");
    ticks(100, 0);
    rd(2'd3, 32'h000, "release_to_idle");
    wr(2'd1, 32'd0, 4'b0001);
    wr(2'd0, 32'd1, 4'b0001);
    ticks(1000, 0);
    rd(2'd3, 32'h100, "attack_rate0");
    wr(2'd1, 32'hAABBCCDD, 4'b0010);
    rd(2'd1, 32'h0080CC00, "rates_byte1_only");
    wr(2'd3, 32'hFFFFFFFF, 4'b1111);
    rd(2'd3, 32'h100, "status_readonly");
    wr(2'd2, 32'h000000FF, 4'b0001);
    wr(2'd1, 32'h0080FFFF, 4'b0111);
    ticks(257, 0);
    rd(2'd3, 32'h2FF, "fast_attack");
    ticks(1, 0);
    rd(2'd3, 32'h3FF, "sustain_ff_first_tick");
    wr(2'd2, 32'd0, 4'b0001);
    rd(2'd3, 32'h300, "sustain_zero");
    chk("active_sustain_zero", {31'd0, active}, 32'd1);
    repeat (400) begin
      in_s = 8'($urandom);
      case ($urandom_range(0, 3))
        0: wr(2'd0, 32'($urandom_range(0, 1)), 4'b0001);
        1: wr(2'd1, $urandom, 4'($urandom));
        2: wr(2'd2, $urandom, 4'b0001);
        default: bus_op(2'($urandom), 32'd0, 4'd0, 1'($urandom), v);
      endcase
      repeat ($urandom_range(1, 40)) step(1'($urandom));
    end
    wr(2'd1, 32'h00101010, 4'b0111);
    wr(2'd0, 32'd0, 4'b0001);
    wr(2'd0, 32'd1, 4'b0001);
    ticks(5, 0);
    resetn = 1'b0;
    step(1'b0);
    chk("midreset_active", {31'd0, active}, 32'd0);
    chk("midreset_out", {24'd0, out}, 32'd0);
    resetn = 1'b1;
    rd(2'd3, 32'd0, "midreset_status");
    rd(2'd0, 32'd0, "midreset_ctrl");
    rd(2'd1, 32'd0, "midreset_rates");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/envelope_adsr.md
Name: envelope_adsr

Overview:
- Memory-mapped ADSR envelope generator / VCA inserted between one oscillator output and a mixier channel input.
- Scales the 8-bit oscillator sample by an envelope level.
- The envelope level advances once per sample tick (sampling counter overflow).
- CPU controls gate, rates and sustain through the standard valid/ready peripheral bus; top-level decode at mem_addr[31:24] == 8'h0D.

Parameters:
- DATA_W, 8, width of sample in/out.
- ACC_W, 16, envelope accumulator width (>= 9); level = acc[ACC_W-1:ACC_W-8].

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-low
- valid  in  1  bus request (already gated by address select)
- ready  out  1  bus acknowledge, one-cycle pulse
- wstrb  in  4  byte write strobes; 0 = read
- addr  in  32  byte address; addr[3:2] selects register
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready=1
- in  in  DATA_W  oscillator sample (unsigned)
- tick  in  1  single-cycle sample strobe
- out  out  DATA_W  enveloped sample to mixier
- active  out  1  high when state != IDLE

Behaviour:
- Reset: ready=0, rdata=0, out=0, active=0, state=IDLE, acc=0, all registers 0.
- Bus: ready <= valid && !ready, so there is 1 wait cycle per access and never back-to-back.
- Write is committed in the ready cycle, per byte per wstrb. rdata is registered in the same cycle.
- Registers:
  - 0x0 CTRL: [0] gate, R/W.
  - 0x4 RATES: [7:0] attack A, [15:8] decay D, [23:16] release R.
  - 0x8 SUSTAIN: [7:0] S.
  - 0xC STATUS (RO, writes ignored): [7:0] level, [10:8] state.
  - Unused bits read 0.
- States (3-bit): IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Gate events are evaluated every clk, on the cycle after the CTRL write commits:
  - Gate 0->1: ATTACK from the current acc (no reset to 0).
  - Gate 1->0: RELEASE if state != IDLE.
  - A write of the same gate value is not an event.
- Tick updates apply only when no gate event occurs in that cycle; the gate event wins and that tick is dropped.
  - ATTACK: acc+A (zero-extended) saturates at all-ones; on reaching all-ones -> DECAY.
  - DECAY: target T = {S, zeros}. If acc-D <= T or it underflows, acc=T -> SUSTAIN; else acc -= D.
  - SUSTAIN: acc = T continuously (every clk), tracking SUSTAIN writes.
  - RELEASE: if acc-R <= 0 or it underflows, acc=0 -> IDLE; else acc -= R.
  - IDLE: acc holds 0.
- Rate 0 means no movement: the envelope stays in that state indefinitely. A gate event is the only exit.
- S=0xFF: DECAY exits on its first tick. S=0x00 with D>0: decays to 0 and stays in SUSTAIN, active=1.
- Output: out <= (in * level) >> DATA_W, registered, 1-cycle latency from in/level. With level=0xFF, out = in - (in>0 ? 1 : 0) (truncation accepted).
- active is driven directly from the state register.
- Reset asserted mid-envelope: everything returns to reset values on the next clk edge.

Decomposition:
- Shared package envelope_pkg holds:
  - state encoding constants
  - register offset constants (CTRL/RATES/SUSTAIN/STATUS)
  - STATUS field positions
- One sub-module, env_vca: registered DATA_W x 8 unsigned multiply, output = top DATA_W bits, synchronous reset to 0.

Test Plan:
- Reset then read STATUS -> rdata=0. ready pulses exactly 1 cycle, 1 cycle after valid.
- A=0x40, D=0x10, S=0x80, gate=1, tick every 4 clks -> ATTACK for 1024 ticks, DECAY for 2048 ticks, then SUSTAIN with level=0x80. With in=0xC8, out=0x64.
- In SUSTAIN, write gate=0 with R=0x80 -> RELEASE. acc reaches 0 after 256 ticks, then IDLE, active=0, out=0.
- Gate 1->0->1 during ATTACK at level 0x30 -> ATTACK restarts from 0x30 (not 0). STATUS shows state=1.
- Gate write and tick in the same cycle -> the tick is dropped and acc does not change that cycle.
- A=0, gate=1, 1000 ticks -> stays in ATTACK with level=0. A write of wstrb=4'b0010 to RATES changes only D.
